msrv32_alu_arbiter: RTL and testbench

MSRV32_ALU_ARBITER -- requirements
Module: msrv32_alu_arbiter

---
 rtl/msrv32_alu_arbiter.sv | 109 ++++++++++
 tb/tb_msrv32_alu_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_alu_arbiter.sv
// Two-requester round-robin front end for a single shared msrv32_alu.
// Each accepted operation runs IDLE -> EXEC -> RESP and is held in RESP until its owner takes the result.
module msrv32_alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        req_valid_0_in,
  input  logic        req_valid_1_in,
  output logic        req_ready_0_out,
  output logic        req_ready_1_out,
  input  logic [31:0] op_1_0_in,
  input  logic [31:0] op_2_0_in,
  input  logic [3:0]  opcode_0_in,
  input  logic [31:0] op_1_1_in,
  input  logic [31:0] op_2_1_in,
  input  logic [3:0]  opcode_1_in,
  output logic        rsp_valid_0_out,
  output logic        rsp_valid_1_out,
  input  logic        rsp_ready_0_in,
  input  logic        rsp_ready_1_in,
  output logic [31:0] result_0_out,
  output logic [31:0] result_1_out,
  output logic [31:0] alu_op_1_out,
  output logic [31:0] alu_op_2_out,
  output logic [3:0]  alu_opcode_out,
  input  logic [31:0] alu_result_in,
  output logic        busy_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic        prio;
  logic        owner;
  logic [31:0] op_1_q;
  logic [31:0] op_2_q;
  logic [3:0]  opcode_q;
  logic [31:0] result_q;
  logic        grant_0, grant_1;
  logic        accept;
  logic        rsp_taken;

  // Grants are gated by reset so no ready escapes while the block is held in reset.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (state == IDLE && !ms_riscv32_mp_rst_in) begin
      grant_0 = req_valid_0_in && (prio == 1'b0 || !req_valid_1_in);
      grant_1 = req_valid_1_in && (prio == 1'b1 || !req_valid_0_in);
    end
  end

  assign accept          = grant_0 || grant_1;
  assign req_ready_0_out = grant_0;
  assign req_ready_1_out = grant_1;
  assign rsp_taken       = owner ? rsp_ready_1_in : rsp_ready_0_in;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_taken) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state    <= IDLE;
      prio     <= RR_INIT;
      owner    <= 1'b0;
      op_1_q   <= '0;
      op_2_q   <= '0;
      opcode_q <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner    <= grant_1;
        prio     <= ~grant_1;
        op_1_q   <= grant_1 ? op_1_1_in   : op_1_0_in;
        op_2_q   <= grant_1 ? op_2_1_in   : op_2_0_in;
        opcode_q <= grant_1 ? opcode_1_in : opcode_0_in;
      end
      if (state == EXEC) result_q <= alu_result_in;
    end
  end

  // The shared ALU only sees operands while this block owns it.
  always_comb begin
    alu_op_1_out   = '0;
    alu_op_2_out   = '0;
    alu_opcode_out = '0;
    if (state == EXEC) begin
      alu_op_1_out   = op_1_q;
      alu_op_2_out   = op_2_q;
      alu_opcode_out = opcode_q;
    end
  end

  assign rsp_valid_0_out = (state == RESP) && (owner == 1'b0);
  assign rsp_valid_1_out = (state == RESP) && (owner == 1'b1);
  assign result_0_out    = rsp_valid_0_out ? result_q : '0;
  assign result_1_out    = rsp_valid_1_out ? result_q : '0;
  assign busy_out        = (state != IDLE);

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// Directed bench for msrv32_alu_arbiter: a vector table of single operations plus
// hand-written contention, backpressure, mid-operation reset and late-request sequences.
module tb_msrv32_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0_in, req_valid_1_in;
  logic        req_ready_0_out, req_ready_1_out;
  logic [31:0] op_1_0_in, op_2_0_in, op_1_1_in, op_2_1_in;
  logic [3:0]  opcode_0_in, opcode_1_in;
  logic        rsp_valid_0_out, rsp_valid_1_out;
  logic        rsp_ready_0_in, rsp_ready_1_in;
  logic [31:0] result_0_out, result_1_out;
  logic [31:0] alu_op_1_out, alu_op_2_out;
  logic [3:0]  alu_opcode_out;
  logic [31:0] alu_result_in;
  logic        busy_out;

  int pass_count = 0;
  int check_count = 0;

  typedef struct {
    string       name;
    logic        req;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  opc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  msrv32_alu_arbiter #(.RR_INIT(1'b0)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .req_valid_0_in(req_valid_0_in),
    .req_valid_1_in(req_valid_1_in),
    .req_ready_0_out(req_ready_0_out),
    .req_ready_1_out(req_ready_1_out),
    .op_1_0_in(op_1_0_in),
    .op_2_0_in(op_2_0_in),
    .opcode_0_in(opcode_0_in),
    .op_1_1_in(op_1_1_in),
    .op_2_1_in(op_2_1_in),
    .opcode_1_in(opcode_1_in),
    .rsp_valid_0_out(rsp_valid_0_out),
    .rsp_valid_1_out(rsp_valid_1_out),
    .rsp_ready_0_in(rsp_ready_0_in),
    .rsp_ready_1_in(rsp_ready_1_in),
    .result_0_out(result_0_out),
    .result_1_out(result_1_out),
    .alu_op_1_out(alu_op_1_out),
    .alu_op_2_out(alu_op_2_out),
    .alu_opcode_out(alu_opcode_out),
    .alu_result_in(alu_result_in),
    .busy_out(busy_out)
  );

  // Stand-in for the shared msrv32_alu.
  always_comb begin
    case (alu_opcode_out)
      4'b0000: alu_result_in = alu_op_1_out + alu_op_2_out;
      4'b1000: alu_result_in = alu_op_1_out - alu_op_2_out;
      4'b0001: alu_result_in = alu_op_1_out << alu_op_2_out[4:0];
      4'b0101: alu_result_in = alu_op_1_out >> alu_op_2_out[4:0];
      4'b1101: alu_result_in = $signed(alu_op_1_out) >>> alu_op_2_out[4:0];
      4'b0100: alu_result_in = alu_op_1_out ^ alu_op_2_out;
      4'b0110: alu_result_in = alu_op_1_out | alu_op_2_out;
      4'b0111: alu_result_in = alu_op_1_out & alu_op_2_out;
      default: alu_result_in = 32'd0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic k, input logic valid, input logic [31:0] op1,
                               input logic [31:0] op2, input logic [3:0] opc);
    if (k == 1'b0) begin
      req_valid_0_in = valid; op_1_0_in = op1; op_2_0_in = op2; opcode_0_in = opc;
    end else begin
      req_valid_1_in = valid; op_1_1_in = op1; op_2_1_in = op2; opcode_1_in = opc;
    end
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    rsp_ready_0_in = 1'b0;
    rsp_ready_1_in = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One operation from requester k with the result taken immediately.
  task automatic runOne(input vec_t v);
    int waited = 0;
    logic [31:0] res_own, res_oth;
    logic        val_own, val_oth, rdy_own, rdy_oth;
    @(negedge clk);
    applyStimulus(v.req, 1'b1, v.op1, v.op2, v.opc);
    if (v.req) rsp_ready_1_in = 1'b1; else rsp_ready_0_in = 1'b1;
    #1;
    rdy_own = v.req ? req_ready_1_out : req_ready_0_out;
    while (!rdy_own && waited < 10) begin
      @(negedge clk); #1;
      waited++;
      rdy_own = v.req ? req_ready_1_out : req_ready_0_out;
    end
    checkOutput({v.name, "_grant"}, {31'd0, rdy_own}, 32'd1);
    rdy_oth = v.req ? req_ready_0_out : req_ready_1_out;
    checkOutput({v.name, "_other_ready"}, {31'd0, rdy_oth}, 32'd0);
    @(negedge clk);
    applyStimulus(v.req, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checkOutput({v.name, "_alu_op1"}, alu_op_1_out, v.op1);
    checkOutput({v.name, "_alu_opcode"}, {28'd0, alu_opcode_out}, {28'd0, v.opc});
    @(negedge clk); #1;
    val_own = v.req ? rsp_valid_1_out : rsp_valid_0_out;
    val_oth = v.req ? rsp_valid_0_out : rsp_valid_1_out;
    res_own = v.req ? result_1_out : result_0_out;
    res_oth = v.req ? result_0_out : result_1_out;
    checkOutput({v.name, "_rsp_valid"}, {31'd0, val_own}, 32'd1);
    checkOutput({v.name, "_other_rsp_valid"}, {31'd0, val_oth}, 32'd0);
    checkOutput({v.name, "_result"}, res_own, v.exp);
    checkOutput({v.name, "_other_result"}, res_oth, 32'd0);
    @(negedge clk); #1;
    val_own = v.req ? rsp_valid_1_out : rsp_valid_0_out;
    checkOutput({v.name, "_rsp_one_cycle"}, {31'd0, val_own}, 32'd0);
    checkOutput({v.name, "_idle"}, {31'd0, busy_out}, 32'd0);
    rsp_ready_0_in = 1'b0;
    rsp_ready_1_in = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"add_r0",  1'b0, 32'd5,          32'd3,  4'b0000, 32'd8};
    vecs[1] = '{"srl_r1",  1'b1, 32'd16,         32'd3,  4'b0101, 32'd2};
    vecs[2] = '{"addwrap", 1'b0, 32'hFFFF_FFFF,  32'd1,  4'b0000, 32'd0};
    vecs[3] = '{"srlmsb",  1'b1, 32'h8000_0000,  32'd31, 4'b0101, 32'd1};
    vecs[4] = '{"sub",     1'b0, 32'd3,          32'd5,  4'b1000, 32'hFFFF_FFFE};
    vecs[5] = '{"xor",     1'b1, 32'h0000_F0F0,  32'h0000_0FF0, 4'b0100, 32'h0000_FF00};
    vecs[6] = '{"sra",     1'b0, 32'h8000_0000,  32'd4,  4'b1101, 32'hF800_0000};

    rst = 1'b1;
    clearInputs();
    req_valid_0_in = 1'b1;
    req_valid_1_in = 1'b1;
    #12;
    checkOutput("rst_ready0", {31'd0, req_ready_0_out}, 32'd0);
    checkOutput("rst_ready1", {31'd0, req_ready_1_out}, 32'd0);
    checkOutput("rst_busy",   {31'd0, busy_out}, 32'd0);
    checkOutput("rst_rspv0",  {31'd0, rsp_valid_0_out}, 32'd0);
    checkOutput("rst_alu_op1", alu_op_1_out, 32'd0);
    checkOutput("rst_result0", result_0_out, 32'd0);
    doReset();

    for (int i = 0; i < 7; i++) runOne(vecs[i]);

    // Contention: both valid every cycle, grants r0,r1,r0,r1 on cycles 0,3,6,9.
    doReset();
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'd1, 32'd1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 32'd2, 32'd2, 4'b0000);
    rsp_ready_0_in = 1'b1;
    rsp_ready_1_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      checkOutput($sformatf("cont_ready0_c%0d", c), {31'd0, req_ready_0_out},
                  {31'd0, (c % 3 == 0) && ((c / 3) % 2 == 0)});
      checkOutput($sformatf("cont_ready1_c%0d", c), {31'd0, req_ready_1_out},
                  {31'd0, (c % 3 == 0) && ((c / 3) % 2 == 1)});
      @(negedge clk);
    end

    // Backpressure: r0 holds its result for 4 cycles while r1 waits.
    doReset();
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd23, 4'b0000);
    applyStimulus(1'b1, 1'b1, 32'd7, 32'd1, 4'b0000);
    rsp_ready_0_in = 1'b0;
    rsp_ready_1_in = 1'b1;
    #1;
    checkOutput("bp_ready0", {31'd0, req_ready_0_out}, 32'd1);
    @(negedge clk);
    req_valid_0_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("bp_rspv0_%0d", i), {31'd0, rsp_valid_0_out}, 32'd1);
      checkOutput($sformatf("bp_result0_%0d", i), result_0_out, 32'd123);
      checkOutput($sformatf("bp_ready1_%0d", i), {31'd0, req_ready_1_out}, 32'd0);
      checkOutput($sformatf("bp_rspv1_%0d", i), {31'd0, rsp_valid_1_out}, 32'd0);
    end
    @(negedge clk);
    rsp_ready_0_in = 1'b1;
    #1;
    checkOutput("bp_hs_rspv0", {31'd0, rsp_valid_0_out}, 32'd1);
    checkOutput("bp_hs_ready1", {31'd0, req_ready_1_out}, 32'd0);
    @(negedge clk); #1;
    checkOutput("bp_after_ready1", {31'd0, req_ready_1_out}, 32'd1);
    checkOutput("bp_after_rspv0", {31'd0, rsp_valid_0_out}, 32'd0);
    @(negedge clk);
    req_valid_1_in = 1'b0;
    @(negedge clk); #1;
    checkOutput("bp_r1_result", result_1_out, 32'd8);

    // Reset in EXEC aborts the operation and restores RR_INIT priority.
    doReset();
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'd9, 32'd1, 4'b0000);
    rsp_ready_0_in = 1'b1;
    #1;
    checkOutput("mr_ready0", {31'd0, req_ready_0_out}, 32'd1);
    @(negedge clk);
    req_valid_1_in = 1'b1;
    #1;
    checkOutput("mr_exec_op1", alu_op_1_out, 32'd9);
    rst = 1'b1;
    #1;
    checkOutput("mr_busy", {31'd0, busy_out}, 32'd0);
    checkOutput("mr_alu_op1", alu_op_1_out, 32'd0);
    checkOutput("mr_ready0", {31'd0, req_ready_0_out}, 32'd0);
    checkOutput("mr_ready1", {31'd0, req_ready_1_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid_0_in = 1'b0;
    req_valid_1_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("mr_no_rsp_%0d", i), {30'd0, rsp_valid_1_out, rsp_valid_0_out}, 32'd0);
      @(negedge clk);
    end
    req_valid_0_in = 1'b1;
    req_valid_1_in = 1'b1;
    #1;
    checkOutput("mr_regrant0", {31'd0, req_ready_0_out}, 32'd1);
    checkOutput("mr_regrant1", {31'd0, req_ready_1_out}, 32'd0);

    // Late request: r1 arrives during r0's EXEC and wins the next IDLE on priority.
    doReset();
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'd4, 32'd4, 4'b0000);
    rsp_ready_0_in = 1'b1;
    #1;
    checkOutput("late_ready0", {31'd0, req_ready_0_out}, 32'd1);
    @(negedge clk);
    req_valid_0_in = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'd6, 32'd1, 4'b0000);
    #1;
    checkOutput("late_exec_ready1", {31'd0, req_ready_1_out}, 32'd0);
    @(negedge clk);
    req_valid_0_in = 1'b1;
    #1;
    checkOutput("late_resp_ready1", {31'd0, req_ready_1_out}, 32'd0);
    checkOutput("late_resp_result0", result_0_out, 32'd8);
    @(negedge clk); #1;
    checkOutput("late_idle_ready1", {31'd0, req_ready_1_out}, 32'd1);
    checkOutput("late_idle_ready0", {31'd0, req_ready_0_out}, 32'd0);
    @(negedge clk);
    clearInputs();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
